// File: rtl/xoodyak_seq.sv
// Xoodyak phase sequencer: walks KEY/NONCE/AD/CRYPT/SQZ, each an absorb cycle
// followed by NROUNDS Xoodoo rounds, and feeds round index/constant to the datapath.
module xoodyak_seq #(
    parameter int         NROUNDS  = 12,
    parameter logic [7:0] CD_KEY   = 8'h02,
    parameter logic [7:0] CD_ABS   = 8'h03,
    parameter logic [7:0] CD_CRYPT = 8'h80,
    parameter logic [7:0] CD_SQZ   = 8'h40
) (
    input  logic        eph1,
    input  logic        reset,
    input  logic        start,
    input  logic        opmode,
    input  logic        hold,
    input  logic        abort,
    output logic        busy,
    output logic [2:0]  phase,
    output logic        clr_state,
    output logic        absorb_en,
    output logic [7:0]  cd,
    output logic        rnd_en,
    output logic [3:0]  rnd_idx,
    output logic [11:0] rc,
    output logic        mode_o,
    output logic        text_valid,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ABS,
        S_PERM,
        S_DONE
    } state_t;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_KEY   = 3'd1;
    localparam logic [2:0] PH_NONCE = 3'd2;
    localparam logic [2:0] PH_AD    = 3'd3;
    localparam logic [2:0] PH_CRYPT = 3'd4;
    localparam logic [2:0] PH_SQZ   = 3'd5;
    localparam logic [2:0] PH_DONE  = 3'd6;

    localparam logic [3:0] LAST_RND = 4'(NROUNDS - 1);
    // Reduced-round variants use the tail of the 12-entry constant table.
    localparam logic [3:0] RC_BASE  = 4'(12 - NROUNDS);

    state_t     state_q;
    logic [2:0] phase_q;
    logic [3:0] rnd_q;
    logic       mode_q;

    function automatic logic [11:0] rcLookup(input logic [3:0] idx);
        case (idx)
            4'd0:    rcLookup = 12'h058;
            4'd1:    rcLookup = 12'h038;
            4'd2:    rcLookup = 12'h3C0;
            4'd3:    rcLookup = 12'h0D0;
            4'd4:    rcLookup = 12'h120;
            4'd5:    rcLookup = 12'h014;
            4'd6:    rcLookup = 12'h060;
            4'd7:    rcLookup = 12'h02C;
            4'd8:    rcLookup = 12'h380;
            4'd9:    rcLookup = 12'h0F0;
            4'd10:   rcLookup = 12'h1A0;
            4'd11:   rcLookup = 12'h012;
            default: rcLookup = 12'h000;
        endcase
    endfunction

    // Abort beats hold, and hold only freezes a running operation, so a start
    // arriving in IDLE is accepted regardless of hold.
    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            phase_q <= PH_IDLE;
            rnd_q   <= 4'd0;
            mode_q  <= 1'b0;
        end else if (abort && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            phase_q <= PH_IDLE;
            rnd_q   <= 4'd0;
        end else if (!(hold && state_q != S_IDLE)) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ABS;
                        phase_q <= PH_KEY;
                        mode_q  <= opmode;
                    end
                end
                S_ABS: begin
                    state_q <= S_PERM;
                    rnd_q   <= 4'd0;
                end
                S_PERM: begin
                    if (rnd_q == LAST_RND) begin
                        rnd_q <= 4'd0;
                        if (phase_q == PH_SQZ) begin
                            state_q <= S_DONE;
                            phase_q <= PH_DONE;
                        end else begin
                            state_q <= S_ABS;
                            phase_q <= phase_q + 3'd1;
                        end
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    phase_q <= PH_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    phase_q <= PH_IDLE;
                    rnd_q   <= 4'd0;
                end
            endcase
        end
    end

    // Strobes are decoded from the registered state and suppressed while stalled.
    always_comb begin
        busy       = (state_q != S_IDLE);
        phase      = phase_q;
        rnd_idx    = rnd_q;
        mode_o     = mode_q;
        absorb_en  = (state_q == S_ABS) && !hold;
        rnd_en     = (state_q == S_PERM) && !hold;
        done       = (state_q == S_DONE) && !hold;
        clr_state  = absorb_en && (phase_q == PH_KEY);
        text_valid = absorb_en && (phase_q == PH_CRYPT);
        rc         = rnd_en ? rcLookup(RC_BASE + rnd_q) : 12'h000;
        cd         = 8'h00;
        if (absorb_en) begin
            case (phase_q)
                PH_KEY:            cd = CD_KEY;
                PH_NONCE, PH_AD:   cd = CD_ABS;
                PH_CRYPT:          cd = CD_CRYPT;
                PH_SQZ:            cd = CD_SQZ;
                default:           cd = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_xoodyak_seq.sv
// Directed bench for xoodyak_seq: full runs, hold, abort, mid-run reset and a
// reduced-round instance, checked against hand-derived cycle expectations.
module tb_xoodyak_seq;

    logic        eph1 = 1'b0;
    logic        reset;
    logic        start;
    logic        opmode;
    logic        hold;
    logic        abort;
    logic        start6;

    logic        busy, clr_state, absorb_en, rnd_en, mode_o, text_valid, done;
    logic [2:0]  phase;
    logic [7:0]  cd;
    logic [3:0]  rnd_idx;
    logic [11:0] rc;

    logic        busy6, clr6, absorb6, rnd_en6, mode6, text6, done6;
    logic [2:0]  phase6;
    logic [7:0]  cd6;
    logic [3:0]  idx6;
    logic [11:0] rc6;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  cdTab [5]  = '{8'h02, 8'h03, 8'h03, 8'h80, 8'h40};
    logic [11:0] rcTab [12] = '{12'h058, 12'h038, 12'h3C0, 12'h0D0, 12'h120, 12'h014,
                                12'h060, 12'h02C, 12'h380, 12'h0F0, 12'h1A0, 12'h012};

    xoodyak_seq dut (
        .eph1(eph1), .reset(reset), .start(start), .opmode(opmode),
        .hold(hold), .abort(abort), .busy(busy), .phase(phase),
        .clr_state(clr_state), .absorb_en(absorb_en), .cd(cd),
        .rnd_en(rnd_en), .rnd_idx(rnd_idx), .rc(rc), .mode_o(mode_o),
        .text_valid(text_valid), .done(done)
    );

    xoodyak_seq #(.NROUNDS(6)) dut6 (
        .eph1(eph1), .reset(reset), .start(start6), .opmode(1'b0),
        .hold(1'b0), .abort(1'b0), .busy(busy6), .phase(phase6),
        .clr_state(clr6), .absorb_en(absorb6), .cd(cd6),
        .rnd_en(rnd_en6), .rnd_idx(idx6), .rc(rc6), .mode_o(mode6),
        .text_valid(text6), .done(done6)
    );

    always #5 eph1 = ~eph1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge eph1);
        #2;
        cyc++;
    endtask

    // Pulse start for one edge (edge 0); afterwards we sit in cycle 1.
    task automatic applyStimulus(input logic m);
        start  = 1'b1;
        opmode = m;
        cyc    = 0;
        tick();
        start  = 1'b0;
        opmode = ~m;
    endtask

    // Expected outputs of the 12-round instance in cycle c of an unheld run.
    task automatic checkNominal(input int c, input logic m);
        int p, off;
        logic [31:0] eBusy, ePhase, eAbs, eCd, eClr, eText, eRnd, eIdx, eRc, eDone;
        eBusy = 0; ePhase = 0; eAbs = 0; eCd = 0; eClr = 0; eText = 0;
        eRnd = 0; eIdx = 0; eRc = 0; eDone = 0;
        if (c >= 1 && c <= 65) begin
            p      = (c - 1) / 13;
            off    = (c - 1) % 13;
            eBusy  = 1;
            ePhase = 32'(p + 1);
            eAbs   = (off == 0) ? 1 : 0;
            eCd    = (off == 0) ? 32'(cdTab[p]) : 0;
            eClr   = (c == 1) ? 1 : 0;
            eText  = (c == 40) ? 1 : 0;
            eRnd   = (off != 0) ? 1 : 0;
            eIdx   = (off != 0) ? 32'(off - 1) : 0;
            eRc    = (off != 0) ? 32'(rcTab[off - 1]) : 0;
        end else if (c == 66) begin
            eBusy  = 1;
            ePhase = 6;
            eDone  = 1;
        end
        checkOutput($sformatf("c%0d busy", c), 32'(busy), eBusy);
        checkOutput($sformatf("c%0d phase", c), 32'(phase), ePhase);
        checkOutput($sformatf("c%0d absorb_en", c), 32'(absorb_en), eAbs);
        checkOutput($sformatf("c%0d cd", c), 32'(cd), eCd);
        checkOutput($sformatf("c%0d clr_state", c), 32'(clr_state), eClr);
        checkOutput($sformatf("c%0d text_valid", c), 32'(text_valid), eText);
        checkOutput($sformatf("c%0d rnd_en", c), 32'(rnd_en), eRnd);
        checkOutput($sformatf("c%0d rnd_idx", c), 32'(rnd_idx), eIdx);
        checkOutput($sformatf("c%0d rc", c), 32'(rc), eRc);
        checkOutput($sformatf("c%0d done", c), 32'(done), eDone);
        checkOutput($sformatf("c%0d mode_o", c), 32'(mode_o), 32'(m));
    endtask

    initial begin
        int doneCount;
        int doneAt;

        reset = 1'b0; start = 1'b0; opmode = 1'b0; hold = 1'b0; abort = 1'b0; start6 = 1'b0;

        // Reset state
        repeat (3) tick();
        checkOutput("rst busy", 32'(busy), 0);
        checkOutput("rst phase", 32'(phase), 0);
        checkOutput("rst rnd_idx", 32'(rnd_idx), 0);
        checkOutput("rst rc", 32'(rc), 0);
        checkOutput("rst mode_o", 32'(mode_o), 0);
        checkOutput("rst done", 32'(done), 0);
        checkOutput("rst absorb_en", 32'(absorb_en), 0);
        checkOutput("rst busy6", 32'(busy6), 0);
        reset = 1'b1;
        repeat (2) tick();

        // Nominal encrypt run with ignored start pulses in cycles 10 and 66
        $display("[TB] nominal run with stray starts");
        applyStimulus(1'b0);
        doneCount = 0;
        for (int c = 1; c <= 67; c++) begin
            checkNominal(c, 1'b0);
            if (done) doneCount++;
            start = (c == 10 || c == 66);
            tick();
        end
        start = 1'b0;
        checkOutput("stray start busy", 32'(busy), 0);
        checkOutput("stray start done count", 32'(doneCount), 1);

        // Hold for three cycles at PERM(CRYPT) rnd_idx 7
        $display("[TB] hold test");
        applyStimulus(1'b0);
        while (cyc < 48) tick();
        checkOutput("pre-hold rnd_idx", 32'(rnd_idx), 7);
        checkOutput("pre-hold phase", 32'(phase), 4);
        hold = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("hold%0d rnd_idx", k), 32'(rnd_idx), 7);
            checkOutput($sformatf("hold%0d rnd_en", k), 32'(rnd_en), 0);
            checkOutput($sformatf("hold%0d rc", k), 32'(rc), 0);
            checkOutput($sformatf("hold%0d busy", k), 32'(busy), 1);
            checkOutput($sformatf("hold%0d phase", k), 32'(phase), 4);
            if (k < 2) tick();
        end
        tick();
        hold = 1'b0;
        #1;
        checkOutput("post-hold rnd_idx", 32'(rnd_idx), 7);
        checkOutput("post-hold rnd_en", 32'(rnd_en), 1);
        checkOutput("post-hold rc", 32'(rc), 32'h02C);
        doneAt = 0;
        doneCount = 0;
        while (cyc < 80) begin
            tick();
            if (done) begin
                doneCount++;
                if (doneAt == 0) doneAt = cyc;
            end
        end
        checkOutput("hold done cycle", 32'(doneAt), 69);
        checkOutput("hold done count", 32'(doneCount), 1);

        // Abort in PERM(NONCE), then a full decrypt run
        $display("[TB] abort test");
        applyStimulus(1'b0);
        while (cyc < 16) tick();
        checkOutput("pre-abort phase", 32'(phase), 2);
        checkOutput("pre-abort rnd_en", 32'(rnd_en), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort busy", 32'(busy), 0);
        checkOutput("abort phase", 32'(phase), 0);
        checkOutput("abort rnd_idx", 32'(rnd_idx), 0);
        checkOutput("abort rc", 32'(rc), 0);
        doneCount = 0;
        for (int k = 0; k < 70; k++) begin
            if (done) doneCount++;
            tick();
        end
        checkOutput("abort no done", 32'(doneCount), 0);
        applyStimulus(1'b1);
        for (int c = 1; c <= 67; c++) begin
            checkNominal(c, 1'b1);
            tick();
        end

        // Asynchronous reset in PERM(AD) at rnd_idx 5
        $display("[TB] mid-run reset");
        applyStimulus(1'b1);
        while (cyc < 33) tick();
        checkOutput("pre-reset phase", 32'(phase), 3);
        checkOutput("pre-reset rnd_idx", 32'(rnd_idx), 5);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("inreset%0d busy", k), 32'(busy), 0);
            checkOutput($sformatf("inreset%0d phase", k), 32'(phase), 0);
            checkOutput($sformatf("inreset%0d rnd_idx", k), 32'(rnd_idx), 0);
            checkOutput($sformatf("inreset%0d rc", k), 32'(rc), 0);
            checkOutput($sformatf("inreset%0d mode_o", k), 32'(mode_o), 0);
            checkOutput($sformatf("inreset%0d rnd_en", k), 32'(rnd_en), 0);
            tick();
        end
        reset = 1'b1;
        repeat (2) tick();

        // Six-round instance: tail of the rc table and shorter latency
        $display("[TB] NROUNDS=6 instance");
        start6 = 1'b1;
        cyc = 0;
        tick();
        start6 = 1'b0;
        checkOutput("r6 absorb c1", 32'(absorb6), 1);
        checkOutput("r6 cd c1", 32'(cd6), 32'h02);
        tick();
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("r6 idx%0d", k), 32'(idx6), 32'(k));
            checkOutput($sformatf("r6 rc%0d", k), 32'(rc6), 32'(rcTab[6 + k]));
            tick();
        end
        checkOutput("r6 second absorb", 32'(absorb6), 1);
        doneAt = 0;
        while (cyc < 50) begin
            if (done6 && doneAt == 0) doneAt = cyc;
            tick();
        end
        checkOutput("r6 done cycle", 32'(doneAt), 36);
        checkOutput("r6 idle after", 32'(busy6), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
